// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and port-select encoding for the
// register-file writeback arbiter.
package rf_write_arbiter_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: oldest request first, ties by rr pointer.
// Ports: req_i/older_i per requester, hold_i freezes rr, gnt_o one-hot.
module rr_arb2
  import rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] older_i,
  input  logic       hold_i,
  output logic [1:0] gnt_o
);

  port_e rr_q, rr_d;
  logic  tie;

  always_comb begin
    gnt_o = 2'b00;
    tie   = 1'b0;
    rr_d  = rr_q;
    unique case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        // Differing ages: the flag vector is itself one-hot.
        if (older_i[0] != older_i[1]) begin
          gnt_o = older_i;
        end else begin
          tie   = 1'b1;
          gnt_o = (rr_q == PORT_A) ? 2'b01 : 2'b10;
        end
      end
      default: gnt_o = 2'b00;
    endcase
    if (tie && !hold_i) begin
      rr_d = (rr_q == PORT_A) ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= PORT_A;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B).
// Ports: A/B valid-ready requests in, w_flag/write_code/w_data and pend_mask out.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                w_flag,
  output logic [ADDR_W-1:0]   write_code,
  output logic [DATA_W-1:0]   w_data,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic [1:0]        hv_q, hv_d;
  logic [1:0]        older_q, older_d;
  logic [1:0]        vld_in, rdy, load, gnt;
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [DATA_W-1:0] in_data [2];

  assign vld_in     = {b_valid, a_valid};
  assign in_addr[0] = a_addr;
  assign in_addr[1] = b_addr;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (hv_q),
    .older_i (older_q),
    .hold_i  (flush),
    .gnt_o   (gnt)
  );

  // A hold frees up on the same edge its entry is written.
  assign rdy     = ~{2{flush}} & (~hv_q | gnt);
  assign load    = vld_in & rdy;
  assign a_ready = rdy[0];
  assign b_ready = rdy[1];

  always_comb begin
    hv_d    = hv_q;
    older_d = older_q;
    addr_d  = addr_q;
    data_d  = data_q;
    for (int p = 0; p < 2; p++) begin
      if (flush) begin
        hv_d[p]    = 1'b0;
        older_d[p] = 1'b0;
      end else if (load[p]) begin
        hv_d[p]    = 1'b1;
        older_d[p] = 1'b0;
        addr_d[p]  = in_addr[p];
        data_d[p]  = in_data[p];
      end else if (gnt[p]) begin
        hv_d[p]    = 1'b0;
        older_d[p] = 1'b0;
      end else if (hv_q[p] && load[1-p]) begin
        // A newer entry arrived behind this waiting one.
        older_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q    <= '0;
      older_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      hv_q    <= hv_d;
      older_q <= older_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign w_flag = (|gnt) & ~flush;

  always_comb begin
    write_code = '0;
    w_data     = '0;
    unique case (1'b1)
      gnt[0]: begin
        write_code = addr_q[0];
        w_data     = data_q[0];
      end
      gnt[1]: begin
        write_code = addr_q[1];
        w_data     = data_q[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_mask = '0;
    for (int p = 0; p < 2; p++) begin
      if (hv_q[p]) pend_mask[addr_q[p]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: transaction-level model
// (arrival-time ordering) predicts writes, ready and pend_mask.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, w_flag;
  logic [3:0]  write_code;
  logic [15:0] w_data, pend_mask;

  int tests = 0;
  int fails = 0;

  logic [19:0] exp_q[$];

  bit          sv[2];
  logic [3:0]  sa[2];
  logic [15:0] sd[2];
  bit          rand_en = 1'b0;

  bit          mv[2];
  logic [3:0]  ma[2];
  logic [15:0] md[2];
  int          mt[2];
  int          mrr = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .w_flag     (w_flag),
    .write_code (write_code),
    .w_data     (w_data),
    .pend_mask  (pend_mask)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, want, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (w_flag === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write got=%0h/%0h want=none t=%0t",
                   write_code, w_data, $time);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({write_code, w_data} !== e) begin
            fails++;
            $display("FAIL write got=%0h/%0h want=%0h/%0h t=%0t",
                     write_code, w_data, e[19:16], e[15:0], $time);
          end
        end
      end else if (exp_q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL missing_write got=none want=%0h t=%0t",
                 exp_q[0], $time);
        exp_q.delete();
      end
    end
  end

  // Oldest arrival wins; equal arrival resolved by the rr pointer.
  function automatic int mgrant();
    if (mv[0] && mv[1]) begin
      if (mt[0] < mt[1]) return 0;
      if (mt[1] < mt[0]) return 1;
      return mrr;
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  task automatic regen(input int p);
    sv[p] = ($urandom_range(0, 9) < 6);
    sa[p] = 4'($urandom);
    sd[p] = 16'($urandom);
  endtask

  // One clock cycle; called at posedge+1.
  task automatic step(input bit fl, input bit rs);
    int          w;
    bit          rdy[2];
    logic [15:0] pm;
    a_valid = sv[0]; a_addr = sa[0]; a_data = sd[0];
    b_valid = sv[1]; b_addr = sa[1]; b_data = sd[1];
    flush   = rs ? 1'b0 : fl;
    if (rs) begin
      #1 rst_n = 1'b0;
      mv  = '{0, 0};
      mrr = 0;
      @(negedge clk);
      chk("rst_wflag", 32'(w_flag), 32'd0);
      chk("rst_code", 32'({write_code, w_data}), 32'd0);
      chk("rst_pend", 32'(pend_mask), 32'd0);
      chk("rst_ready", 32'({a_ready, b_ready}), 32'd3);
      @(posedge clk);
      #1 rst_n = 1'b1;
      return;
    end
    w = mgrant();
    for (int p = 0; p < 2; p++) rdy[p] = !fl && (!mv[p] || w == p);
    pm = '0;
    for (int p = 0; p < 2; p++) if (mv[p]) pm[ma[p]] = 1'b1;
    if (w >= 0 && !fl) exp_q.push_back({ma[w], md[w]});
    @(negedge clk);
    chk("a_ready", 32'(a_ready), 32'(rdy[0]));
    chk("b_ready", 32'(b_ready), 32'(rdy[1]));
    chk("pend_mask", 32'(pend_mask), 32'(pm));
    if (w < 0) chk("idle_port", 32'({write_code, w_data}), 32'd0);
    if (fl) chk("flush_wflag", 32'(w_flag), 32'd0);
    @(posedge clk);
    if (fl) begin
      mv = '{0, 0};
    end else begin
      if (w >= 0) begin
        if (mv[0] && mv[1] && mt[0] == mt[1]) mrr = 1 - w;
        mv[w] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (sv[p] && rdy[p]) begin
          mv[p] = 1'b1;
          ma[p] = sa[p];
          md[p] = sd[p];
          mt[p] = cyc;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (!sv[p] || rdy[p]) begin
        if (rand_en) regen(p);
        else sv[p] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_both(input logic [3:0] aa, input logic [15:0] ad,
                          input logic [3:0] ba, input logic [15:0] bd);
    sv[0] = 1'b1; sa[0] = aa; sd[0] = ad;
    sv[1] = 1'b1; sa[1] = ba; sd[1] = bd;
  endtask

  initial begin
    sv = '{0, 0};
    mv = '{0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_wflag", 32'(w_flag), 32'd0);
    chk("init_code", 32'({write_code, w_data}), 32'd0);
    chk("init_pend", 32'(pend_mask), 32'd0);
    chk("init_ready", 32'({a_ready, b_ready}), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    sv[0] = 1'b1; sa[0] = 4'd3; sd[0] = 16'h1234;
    repeat (3) step(0, 0);

    set_both(4'd5, 16'hAAAA, 4'd6, 16'hBBBB);
    repeat (3) step(0, 0);
    set_both(4'd5, 16'hAAAA, 4'd6, 16'hBBBB);
    repeat (3) step(0, 0);

    for (int i = 0; i < 8; i++) begin
      sv[0] = 1'b1; sa[0] = 4'(i); sd[0] = 16'($urandom);
      step(0, 0);
    end
    repeat (2) step(0, 0);

    set_both(4'd7, 16'h0707, 4'd9, 16'h0909);
    step(0, 0);
    sv[0] = 1'b1; sa[0] = 4'd2; sd[0] = 16'h0202;
    repeat (4) step(0, 0);

    sv[1] = 1'b1; sa[1] = 4'd1; sd[1] = 16'h0101;
    step(0, 0);
    set_both(4'd4, 16'h1111, 4'd4, 16'h2222);
    repeat (4) step(0, 0);

    set_both(4'd8, 16'h8888, 4'd9, 16'h9999);
    step(0, 0);
    step(1, 0);
    step(0, 0);

    set_both(4'd0, 16'hC0C0, 4'd15, 16'hF0F0);
    step(0, 0);
    step(0, 1);
    repeat (3) step(0, 0);

    rand_en = 1'b1;
    regen(0);
    regen(1);
    repeat (3000) step($urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0);

    rand_en = 1'b0;
    sv = '{0, 0};
    repeat (5) step(0, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
